// File: rtl/spi_serializer.sv
// rtl/spi_serializer.sv - SPI mode-0 controller-side frame transmitter
// Sends one {read_write, addr, data} command as a 16-bit MSB-first frame on sclk/copi/n_cs.
module spi_serializer #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int IDLE_GAP = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       read_write,
   input  logic [6:0] addr,
   input  logic [7:0] data,
   output logic       sclk,
   output logic       copi,
   output logic       n_cs,
   output logic       busy,
   output logic       done
);

   localparam int HW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int CW = 16;

   if (CLK_DIV < 2 || CS_SETUP < 1 || CS_HOLD < 1 || IDLE_GAP < 1) begin : g_bad_params
      $error("spi_serializer: illegal parameter value");
   end

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [HW-1:0]   half_q, half_d;
   logic [3:0]      bit_q, bit_d;
   logic            phase_q, phase_d;
   logic [15:0]     word_q, word_d;
   logic            frame_d, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         half_q   <= '0;
         bit_q    <= 4'd15;
         phase_q  <= 1'b0;
         word_q   <= '0;
         sclk     <= 1'b0;
         copi     <= 1'b0;
         n_cs     <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         in_ready <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         bit_q    <= bit_d;
         phase_q  <= phase_d;
         word_q   <= word_d;
         sclk     <= (state_d == SHIFT) && phase_d;
         copi     <= frame_d ? word_d[bit_d] : 1'b0;
         n_cs     <= !frame_d;
         busy     <= (state_d != IDLE);
         done     <= done_d;
         in_ready <= (state_d == IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      word_d  = word_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               word_d  = {read_write, addr, data};
               state_d = SETUP;
               cnt_d   = '0;
               bit_d   = 4'd15;
            end
         end
         SETUP: begin
            if (cnt_q == CW'(CS_SETUP - 1)) begin
               state_d = SHIFT;
               phase_d = 1'b1;
               half_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            // Data advances on the falling sclk edge; the last high phase ends straight into HOLD.
            if (half_q == HW'(CLK_DIV - 1)) begin
               half_d = '0;
               if (phase_q) begin
                  phase_d = 1'b0;
                  if (bit_q == 4'd0) begin
                     state_d = HOLD;
                     cnt_d   = '0;
                  end else begin
                     bit_d = bit_q - 4'd1;
                  end
               end else begin
                  phase_d = 1'b1;
               end
            end else begin
               half_d = half_q + 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == CW'(CS_HOLD - 1)) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = (IDLE_GAP == 1) ? IDLE : GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            // The IDLE cycle itself is the last cycle of the gap.
            if (cnt_q == CW'(IDLE_GAP - 2)) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      frame_d = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
   end

endmodule

// File: tb/tb_spi_serializer.sv
// tb/tb_spi_serializer.sv - directed bench for spi_serializer
// Default instance plus a fast instance (CLK_DIV=2, CS_SETUP=1, CS_HOLD=1), observed through a mux.
module tb_spi_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, iv, sel, rw;
   logic [6:0] addr;
   logic [7:0] data;
   logic       in_valid_a, in_valid_b;
   logic       a_ready, a_sclk, a_copi, a_n_cs, a_busy, a_done;
   logic       b_ready, b_sclk, b_copi, b_n_cs, b_busy, b_done;
   logic       m_ready, m_sclk, m_copi, m_n_cs, m_busy, m_done;

   assign in_valid_a = iv & ~sel;
   assign in_valid_b = iv & sel;
   assign m_ready = sel ? b_ready : a_ready;
   assign m_sclk  = sel ? b_sclk  : a_sclk;
   assign m_copi  = sel ? b_copi  : a_copi;
   assign m_n_cs  = sel ? b_n_cs  : a_n_cs;
   assign m_busy  = sel ? b_busy  : a_busy;
   assign m_done  = sel ? b_done  : a_done;

   spi_serializer dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(a_ready),
      .read_write(rw), .addr(addr), .data(data),
      .sclk(a_sclk), .copi(a_copi), .n_cs(a_n_cs), .busy(a_busy), .done(a_done)
   );

   spi_serializer #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(b_ready),
      .read_write(rw), .addr(addr), .data(data),
      .sclk(b_sclk), .copi(b_copi), .n_cs(b_n_cs), .busy(b_busy), .done(b_done)
   );

   int vec = 0;
   int nfail = 0;

   logic [15:0] w;
   int          low, rises, hi, unst, gap, dnl, t;
   logic        dne;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits for n_cs to fall, then records the frame until n_cs rises again.
   task automatic capture(input logic keep, input logic [15:0] nxt, input logic disturb,
                          output logic [15:0] word, output int n_low, output int n_rise,
                          output int n_hi, output int n_unst, output int n_gap,
                          output int n_dlow, output logic d_end);
      int   tt;
      logic prev_sclk, prev_copi;
      word = '0; n_low = 0; n_rise = 0; n_hi = 0; n_unst = 0; n_gap = 0; n_dlow = 0; d_end = 1'b0;
      tt = 0;
      @(negedge clk);
      while (m_n_cs !== 1'b0 && tt < 300) begin
         n_gap++; tt++;
         @(negedge clk);
      end
      if (tt >= 300) begin
         check("cs_fall_timeout", 32'(m_n_cs), 0);
         return;
      end
      check("busy_at_accept", 32'(m_busy), 1);
      check("ready_at_accept", 32'(m_ready), 0);
      if (keep) {rw, addr, data} = nxt;
      else iv = 1'b0;
      prev_sclk = 1'b0;
      prev_copi = m_copi;
      while (m_n_cs === 1'b0 && n_low < 2000) begin
         n_low++;
         if (m_sclk) n_hi++;
         if (m_sclk && !prev_sclk) begin
            n_rise++;
            word = {word[14:0], m_copi};
            if (m_copi !== prev_copi) n_unst++;
         end
         if (m_done) n_dlow++;
         if (disturb && n_low == 40) begin
            check("ready_mid_frame", 32'(m_ready), 0);
            iv = 1'b1;
            {rw, addr, data} = 16'h7E3C;
         end
         if (disturb && n_low == 41) iv = 1'b0;
         prev_sclk = m_sclk;
         prev_copi = m_copi;
         @(negedge clk);
      end
      d_end = m_done;
   endtask

   task automatic check_frame(input string tag, input logic [15:0] exp, input int exp_low,
                              input int exp_hi);
      check({tag, "_word"}, 32'(w), 32'(exp));
      check({tag, "_cs_low"}, low, exp_low);
      check({tag, "_rises"}, rises, 16);
      check({tag, "_sclk_high"}, hi, exp_hi);
      check({tag, "_copi_unstable"}, unst, 0);
      check({tag, "_done_in_frame"}, dnl, 0);
      check({tag, "_done_end"}, 32'(dne), 1);
   endtask

   initial begin
      rst = 1'b1; iv = 1'b0; sel = 1'b0; {rw, addr, data} = 16'h0000;
      repeat (2) @(negedge clk);
      check("rst_sclk", 32'(a_sclk), 0);
      check("rst_n_cs", 32'(a_n_cs), 1);
      check("rst_copi", 32'(a_copi), 0);
      check("rst_busy", 32'(a_busy), 0);
      check("rst_done", 32'(a_done), 0);
      check("rst_ready", 32'(a_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(a_ready), 1);

      // Read of addr 0x05, data 0xA5
      {rw, addr, data} = {1'b1, 7'h05, 8'hA5}; iv = 1'b1;
      capture(1'b0, 16'h0, 1'b0, w, low, rises, hi, unst, gap, dnl, dne);
      check_frame("t1", 16'h85A5, 128, 64);
      check("t1_rw", 32'(w[15]), 1);
      check("t1_addr", 32'(w[14:8]), 32'h05);
      check("t1_data", 32'(w[7:0]), 32'hA5);
      @(negedge clk);
      check("t1_done_one_cycle", 32'(a_done), 0);
      check("t1_ready_idle", 32'(a_ready), 1);
      check("t1_busy_idle", 32'(a_busy), 0);

      // Back-to-back with in_valid held
      {rw, addr, data} = 16'h1234; iv = 1'b1;
      capture(1'b1, 16'h8F00, 1'b0, w, low, rises, hi, unst, gap, dnl, dne);
      check_frame("t2a", 16'h1234, 128, 64);
      capture(1'b0, 16'h0, 1'b0, w, low, rises, hi, unst, gap, dnl, dne);
      check_frame("t2b", 16'h8F00, 128, 64);
      check("t2_cs_high_gap", gap + 1, 2);

      // Mid-frame input changes ignored
      {rw, addr, data} = 16'h3C96; iv = 1'b1;
      capture(1'b0, 16'h0, 1'b1, w, low, rises, hi, unst, gap, dnl, dne);
      check_frame("t3", 16'h3C96, 128, 64);

      // All-zero and all-one frames
      {rw, addr, data} = 16'h0000; iv = 1'b1;
      capture(1'b0, 16'h0, 1'b0, w, low, rises, hi, unst, gap, dnl, dne);
      check_frame("t6a", 16'h0000, 128, 64);
      {rw, addr, data} = 16'hFFFF; iv = 1'b1;
      capture(1'b0, 16'h0, 1'b0, w, low, rises, hi, unst, gap, dnl, dne);
      check_frame("t6b", 16'hFFFF, 128, 64);

      // Reset during the 8th sclk high phase
      {rw, addr, data} = 16'hC3A5; iv = 1'b1;
      t = 0; rises = 0;
      @(negedge clk);
      while (a_n_cs !== 1'b0 && t < 300) begin t++; @(negedge clk); end
      iv = 1'b0;
      while (rises < 8 && t < 1000) begin
         @(negedge clk);
         t++;
         if (a_sclk && a_n_cs === 1'b0) begin
            rises++;
            while (a_sclk && rises < 8 && t < 1000) begin t++; @(negedge clk); end
         end
      end
      check("t4_reached_8th_high", 32'(a_sclk), 1);
      rst = 1'b1;
      @(negedge clk);
      check("t4_sclk", 32'(a_sclk), 0);
      check("t4_n_cs", 32'(a_n_cs), 1);
      check("t4_copi", 32'(a_copi), 0);
      check("t4_busy", 32'(a_busy), 0);
      check("t4_ready_in_rst", 32'(a_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      check("t4_ready_after", 32'(a_ready), 1);
      check("t4_n_cs_after", 32'(a_n_cs), 1);

      // Fast instance
      sel = 1'b1;
      {rw, addr, data} = {1'b1, 7'h25, 8'h5A}; iv = 1'b1;
      capture(1'b0, 16'h0, 1'b0, w, low, rises, hi, unst, gap, dnl, dne);
      check_frame("t5", 16'hA55A, 64, 32);

      $display("== %0d vectors applied, %0d miscompares ==", vec, nfail);
      $finish;
   end

endmodule
